// File: rtl/cnn_conv3x3_sum_pkg.sv
// Shared widths and result layout for the 3x3 multi-channel convolution core.
package cnn_conv3x3_sum_pkg;

    localparam int unsigned BIT_DEPTH_DEF = 8;
    localparam int unsigned KERNEL_TAPS   = 9;
    localparam int unsigned DOT_W         = 19;
    localparam int unsigned SUM_W         = 21;
    localparam int unsigned NUM_CH        = 3;
    localparam int unsigned NUM_FILT      = 3;
    localparam int unsigned RESULT_W      = NUM_FILT * SUM_W;

    localparam int unsigned F0_OFF = 42;
    localparam int unsigned F1_OFF = 21;
    localparam int unsigned F2_OFF = 0;

    // Bit offset of filter f's sum inside the packed result word.
    function automatic int unsigned field_off(input int unsigned f);
        case (f)
            0:       return F0_OFF;
            1:       return F1_OFF;
            default: return F2_OFF;
        endcase
    endfunction

endpackage

// File: rtl/cnn_dot9.sv
// Nine-term product reduction, kept modulo 2^DOT_W.
module cnn_dot9
    import cnn_conv3x3_sum_pkg::*;
#(
    parameter int unsigned PROD_W = 2 * BIT_DEPTH_DEF
) (
    input  logic [KERNEL_TAPS*PROD_W-1:0] prods,
    output logic [DOT_W-1:0]              dot_c
);

    // Accumulate at DOT_W so carries above the top bit are dropped.
    always_comb begin
        dot_c = '0;
        for (int unsigned k = 0; k < KERNEL_TAPS; k++) begin
            dot_c = dot_c + DOT_W'(prods[k*PROD_W +: PROD_W]);
        end
    end

endmodule

// File: rtl/cnn_conv3x3_sum.sv
// Two-stage 3x3 conv core: 81 registered products, then per-filter channel sums.
module cnn_conv3x3_sum
    import cnn_conv3x3_sum_pkg::*;
#(
    parameter int unsigned BIT_DEPTH = BIT_DEPTH_DEF
) (
    input  logic                             clk,
    input  logic                             RESET_n,
    input  logic                             in_valid,
    input  logic [KERNEL_TAPS*BIT_DEPTH-1:0] in_a,
    input  logic [KERNEL_TAPS*BIT_DEPTH-1:0] in_b,
    input  logic [KERNEL_TAPS*BIT_DEPTH-1:0] in_c,
    input  logic [KERNEL_TAPS*BIT_DEPTH-1:0] w_f0,
    input  logic [KERNEL_TAPS*BIT_DEPTH-1:0] w_f1,
    input  logic [KERNEL_TAPS*BIT_DEPTH-1:0] w_f2,
    output logic [RESULT_W-1:0]              result,
    output logic                             out_valid
);

    localparam int unsigned PROD_W = 2 * BIT_DEPTH;
    localparam int unsigned VEC_W  = KERNEL_TAPS * PROD_W;

    logic [KERNEL_TAPS*BIT_DEPTH-1:0] pix_c [NUM_CH];
    logic [KERNEL_TAPS*BIT_DEPTH-1:0] wt_c  [NUM_FILT];
    logic [VEC_W-1:0]                 prod_c  [NUM_CH][NUM_FILT];
    logic [VEC_W-1:0]                 prod_s1 [NUM_CH][NUM_FILT];
    logic                             valid_s1;
    logic [DOT_W-1:0]                 dot_c [NUM_CH][NUM_FILT];
    logic [RESULT_W-1:0]              result_nxt_c;

    // Channel and filter ports as indexable arrays.
    always_comb begin
        pix_c[0] = in_a;
        pix_c[1] = in_b;
        pix_c[2] = in_c;
        wt_c[0]  = w_f0;
        wt_c[1]  = w_f1;
        wt_c[2]  = w_f2;
    end

    // All 81 pixel-by-weight products; element k sits at k*PROD_W internally.
    always_comb begin
        for (int unsigned x = 0; x < NUM_CH; x++) begin
            for (int unsigned f = 0; f < NUM_FILT; f++) begin
                prod_c[x][f] = '0;
                for (int unsigned k = 0; k < KERNEL_TAPS; k++) begin
                    prod_c[x][f][k*PROD_W +: PROD_W] =
                        PROD_W'(pix_c[x][BIT_DEPTH*(KERNEL_TAPS-k)-1 -: BIT_DEPTH]) *
                        PROD_W'(wt_c[f][BIT_DEPTH*(KERNEL_TAPS-k)-1 -: BIT_DEPTH]);
                end
            end
        end
    end

    // Stage 1: capture products (zero on a bubble) with the window's valid.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            valid_s1 <= 1'b0;
            for (int unsigned x = 0; x < NUM_CH; x++) begin
                for (int unsigned f = 0; f < NUM_FILT; f++) begin
                    prod_s1[x][f] <= '0;
                end
            end
        end else begin
            valid_s1 <= in_valid;
            for (int unsigned x = 0; x < NUM_CH; x++) begin
                for (int unsigned f = 0; f < NUM_FILT; f++) begin
                    prod_s1[x][f] <= in_valid ? prod_c[x][f] : '0;
                end
            end
        end
    end

    for (genvar gx = 0; gx < NUM_CH; gx++) begin : g_ch
        for (genvar gf = 0; gf < NUM_FILT; gf++) begin : g_filt
            cnn_dot9 #(
                .PROD_W (PROD_W)
            ) u_dot9 (
                .prods (prod_s1[gx][gf]),
                .dot_c (dot_c[gx][gf])
            );
        end
    end

    // Per-filter channel sum; three 19-bit terms cannot overflow 21 bits.
    always_comb begin
        result_nxt_c = '0;
        for (int unsigned f = 0; f < NUM_FILT; f++) begin
            result_nxt_c[field_off(f) +: SUM_W] = SUM_W'(dot_c[0][f]) +
                                                  SUM_W'(dot_c[1][f]) +
                                                  SUM_W'(dot_c[2][f]);
        end
    end

    // Stage 2: register the sums; a bubble forces a zero result.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            result    <= valid_s1 ? result_nxt_c : '0;
            out_valid <= valid_s1;
        end
    end

endmodule

// File: tb/tb_cnn_conv3x3_sum.sv
// Randomized and directed bench for cnn_conv3x3_sum against an arithmetic model.
module tb_cnn_conv3x3_sum;

    localparam int unsigned BD = 8;
    localparam int unsigned VW = 9 * BD;

    logic          clk;
    logic          RESET_n;
    logic          in_valid;
    logic [VW-1:0] in_a, in_b, in_c, w_f0, w_f1, w_f2;
    logic [62:0]   result;
    logic          out_valid;

    cnn_conv3x3_sum #(.BIT_DEPTH(BD)) dut (
        .clk       (clk),
        .RESET_n   (RESET_n),
        .in_valid  (in_valid),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .w_f0      (w_f0),
        .w_f1      (w_f1),
        .w_f2      (w_f2),
        .result    (result),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [62:0] r;
    } exp_t;

    int   n_tests;
    int   n_fail;
    int   pa [3][9];
    int   pw [3][9];
    exp_t q [$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: per filter, sum over channels of (9-tap dot mod 2^19).
    function automatic logic [62:0] model();
        longint s [3];
        logic [62:0] r;
        for (int f = 0; f < 3; f++) begin
            s[f] = 0;
            for (int x = 0; x < 3; x++) begin
                longint d = 0;
                for (int k = 0; k < 9; k++) d += longint'(pa[x][k]) * longint'(pw[f][k]);
                s[f] += d % 524288;
            end
        end
        r = {21'(s[0]), 21'(s[1]), 21'(s[2])};
        return r;
    endfunction

    function automatic logic [VW-1:0] pack_pix(input int x);
        logic [VW-1:0] v;
        for (int k = 0; k < 9; k++) v[BD*(9-k)-1 -: BD] = 8'(pa[x][k]);
        return v;
    endfunction

    function automatic logic [VW-1:0] pack_wt(input int f);
        logic [VW-1:0] v;
        for (int k = 0; k < 9; k++) v[BD*(9-k)-1 -: BD] = 8'(pw[f][k]);
        return v;
    endfunction

    task automatic fill(input int pv, input int wv);
        for (int x = 0; x < 3; x++)
            for (int k = 0; k < 9; k++) begin
                pa[x][k] = pv;
                pw[x][k] = wv;
            end
    endtask

    // Apply one window (or bubble), clock once, check the output that emerges.
    task automatic step(input logic v, input string tag);
        exp_t e;
        exp_t o;
        in_valid = v;
        in_a = pack_pix(0);
        in_b = pack_pix(1);
        in_c = pack_pix(2);
        w_f0 = pack_wt(0);
        w_f1 = pack_wt(1);
        w_f2 = pack_wt(2);
        e.v = v;
        e.r = v ? model() : 63'd0;
        q.push_back(e);
        @(posedge clk);
        #1;
        o = q.pop_front();
        chk({tag, "_valid"}, 64'(out_valid), 64'(o.v));
        chk({tag, "_result"}, 64'(result), 64'(o.r));
    endtask

    task automatic restart_model();
        exp_t b;
        b.v = 1'b0;
        b.r = '0;
        q.delete();
        q.push_back(b);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        RESET_n  = 1'b0;
        in_valid = 1'b0;
        fill(0, 0);
        in_a = '0; in_b = '0; in_c = '0;
        w_f0 = '0; w_f1 = '0; w_f2 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        RESET_n = 1'b1;
        restart_model();

        // Ones: each field 27, single-cycle out_valid.
        fill(1, 1);
        step(1'b1, "ones");
        fill(0, 0);
        step(1'b0, "ones_lat");
        chk("ones_field", 64'(result), {1'b0, 21'd27, 21'd27, 21'd27});
        step(1'b0, "ones_tail");

        // All 255: dot wraps to 60937, field 182811.
        fill(255, 255);
        step(1'b1, "max");
        fill(0, 0);
        step(1'b0, "max_lat");
        chk("max_field", 64'(result), {1'b0, 21'd182811, 21'd182811, 21'd182811});

        // Element position check.
        fill(0, 0);
        pa[0][4] = 10;
        pw[1][4] = 3;
        pw[0][0] = 7;
        step(1'b1, "pos");
        fill(0, 0);
        step(1'b0, "pos_lat");
        chk("pos_field", 64'(result), {1'b0, 21'd0, 21'd30, 21'd0});

        // Streaming 5 back-to-back windows.
        for (int i = 1; i <= 5; i++) begin
            fill(0, 1);
            for (int k = 0; k < 9; k++) pa[0][k] = i;
            step(1'b1, "stream");
        end
        fill(0, 0);
        step(1'b0, "stream_end");

        // Valid, bubble, valid.
        fill(2, 3);
        step(1'b1, "bub0");
        step(1'b0, "bub1");
        fill(4, 5);
        step(1'b1, "bub2");
        fill(0, 0);
        step(1'b0, "bub3");

        // Reset with two windows in flight.
        fill(7, 9);
        step(1'b1, "rst_a");
        step(1'b1, "rst_b");
        RESET_n = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_result", 64'(result), 64'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        RESET_n = 1'b1;
        restart_model();
        fill(0, 0);
        for (int i = 0; i < 3; i++) step(1'b0, "rst_after");

        // Randomized traffic, with occasional saturated windows.
        for (int n = 0; n < 300; n++) begin
            logic sat;
            sat = ($urandom_range(0, 7) == 0);
            for (int x = 0; x < 3; x++)
                for (int k = 0; k < 9; k++) begin
                    pa[x][k] = sat ? 255 - $urandom_range(0, 3) : $urandom_range(0, 255);
                    pw[x][k] = sat ? 255 - $urandom_range(0, 3) : $urandom_range(0, 255);
                end
            step(($urandom_range(0, 3) != 0), "rand");
        end
        fill(0, 0);
        step(1'b0, "drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
